store_commit_buffer: RTL and testbench

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer_pkg.sv | 16 +
 rtl/scb_drain_fifo.sv | 65 ++++++
 rtl/store_commit_buffer.sv | 156 +++++++++++++++
 tb/tb_store_commit_buffer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_commit_buffer_pkg.sv
// Shared parameters for the store commit buffer: default widths and reorder-buffer tag constants.
package store_commit_buffer_pkg;

  localparam int unsigned SCB_DEPTH     = 4;
  localparam int unsigned SCB_WORD_SIZE = 32;
  localparam int unsigned SCB_RB_INDEX  = 3;

  // Tag held by an empty slot, and the all-ones tag reserved for "ready" markers.
  localparam logic [SCB_RB_INDEX-1:0] RB_NULL  = '0;
  localparam logic [SCB_RB_INDEX-1:0] RB_READY = '1;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/scb_drain_fifo.sv
// Slot-index FIFO holding committed stores in commit order until memory accepts them.
// With STORE_FWD_EN defined it also exposes its contents in age order.
module scb_drain_fifo
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SCB_DEPTH,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
`ifdef STORE_FWD_EN
  output logic [IDX_W-1:0] order_idx_c [DEPTH],
  output logic [IDX_W:0]   count_c,
`endif
  output logic [IDX_W-1:0] head_idx_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic [IDX_W-1:0] entries [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count      = wr_ptr - rd_ptr;
  assign full_c     = (count == PTR_W'(DEPTH));
  assign empty_c    = (count == '0);
  assign head_idx_c = entries[rd_ptr[IDX_W-1:0]];
  assign do_push    = push && !full_c;
  assign do_pop     = pop && !empty_c;

  // Pointers
  always_ff @(posedge clk or posedge reset) begin : ptr_regs
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage, qualified by the pointers so it needs no reset
  always_ff @(posedge clk) begin : entry_regs
    if (do_push) entries[wr_ptr[IDX_W-1:0]] <= push_idx;
  end

`ifdef STORE_FWD_EN
  assign count_c = count;

  always_comb begin : age_order
    for (int k = 0; k < int'(DEPTH); k++) begin
      order_idx_c[k] = entries[rd_ptr[IDX_W-1:0] + IDX_W'(k)];
    end
  end
`endif

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds completed stores until the ROB commits them, then drains them to memory in commit order.
// Optional committed-store load forwarding is enabled with STORE_FWD_EN.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = SCB_DEPTH,
  parameter int unsigned WORD_SIZE = SCB_WORD_SIZE,
  parameter int unsigned RB_INDEX  = SCB_RB_INDEX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 st_valid,
  input  logic [WORD_SIZE-1:0] st_addr,
  input  logic [WORD_SIZE-1:0] st_data,
  input  logic [RB_INDEX-1:0]  st_rb,
  output logic                 st_ready,
  input  logic                 commit_valid,
  input  logic [RB_INDEX-1:0]  commit_rb,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_ack,
  output logic                 commit_err,
`ifdef STORE_FWD_EN
  input  logic                 ld_valid,
  input  logic [WORD_SIZE-1:0] ld_addr,
  output logic                 ld_hit,
  output logic [WORD_SIZE-1:0] ld_data,
`endif
  output logic                 empty
);

  localparam int unsigned IDX_W = idx_width(DEPTH);

  logic [DEPTH-1:0]     slot_busy;
  logic [DEPTH-1:0]     slot_committed;
  logic [WORD_SIZE-1:0] slot_addr [DEPTH];
  logic [WORD_SIZE-1:0] slot_data [DEPTH];
  logic [RB_INDEX-1:0]  slot_rb   [DEPTH];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             match_found;
  logic [IDX_W-1:0] match_idx;
  logic [IDX_W-1:0] commit_idx;
  logic [IDX_W-1:0] head_idx;
  logic             capture;
  logic             bypass;
  logic             commit_hit;
  logic             pop;
  logic             drain_full;
  logic             drain_empty;

  // Lowest free slot and lowest pending slot carrying the committing tag
  always_comb begin : slot_search
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (slot_busy[i] && !slot_committed[i] && (slot_rb[i] == commit_rb)) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end

  assign st_ready   = free_found;
  assign empty      = ~|slot_busy;
  assign capture    = st_valid && free_found && !flush;
  // A store arriving this cycle can be committed at once when no held slot owns the tag
  assign bypass     = commit_valid && !match_found && capture && (st_rb == commit_rb);
  assign commit_hit = commit_valid && (match_found || bypass) && !drain_full;
  assign commit_idx = match_found ? match_idx : free_idx;

  assign mem_req  = !drain_empty;
  assign pop      = mem_req && mem_ack;
  assign mem_addr = mem_req ? slot_addr[head_idx] : '0;
  assign mem_data = mem_req ? slot_data[head_idx] : '0;

  // Slot state; a commit landing in a flush cycle protects its slot from the flush
  always_ff @(posedge clk or posedge reset) begin : slot_regs
    if (reset) begin
      slot_busy      <= '0;
      slot_committed <= '0;
      commit_err     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_addr[i] <= '0;
        slot_data[i] <= '0;
        slot_rb[i]   <= RB_INDEX'(RB_NULL);
      end
    end else begin
      commit_err <= commit_valid && !commit_hit;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (pop && (head_idx == IDX_W'(i))) begin
          slot_busy[i]      <= 1'b0;
          slot_committed[i] <= 1'b0;
        end
        if (capture && (free_idx == IDX_W'(i))) begin
          slot_busy[i] <= 1'b1;
          slot_addr[i] <= st_addr;
          slot_data[i] <= st_data;
          slot_rb[i]   <= st_rb;
        end
        if (commit_hit && (commit_idx == IDX_W'(i))) begin
          slot_committed[i] <= 1'b1;
        end else if (flush && slot_busy[i] && !slot_committed[i]) begin
          slot_busy[i] <= 1'b0;
        end
      end
    end
  end

`ifdef STORE_FWD_EN
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] drain_order [DEPTH];
  logic [CNT_W-1:0] drain_count;

  // Walk the drain queue oldest to youngest so the youngest matching store wins
  always_comb begin : load_forward
    ld_hit  = 1'b0;
    ld_data = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (ld_valid && (CNT_W'(k) < drain_count) && (slot_addr[drain_order[k]] == ld_addr)) begin
        ld_hit  = 1'b1;
        ld_data = slot_data[drain_order[k]];
      end
    end
  end
`endif

  scb_drain_fifo #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_drain_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (commit_hit),
    .push_idx    (commit_idx),
    .pop         (pop),
`ifdef STORE_FWD_EN
    .order_idx_c (drain_order),
    .count_c     (drain_count),
`endif
    .head_idx_c  (head_idx),
    .full_c      (drain_full),
    .empty_c     (drain_empty)
  );

endmodule

// File: tb/tb_store_commit_buffer.sv
// Randomised and directed bench for store_commit_buffer against a slot/queue reference model.
module tb_store_commit_buffer;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_rb;
  logic        st_ready;
  logic        commit_valid;
  logic [2:0]  commit_rb;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        commit_err;
  logic        empty;
`ifdef STORE_FWD_EN
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr  = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
`endif

  always #5 clk = ~clk;

  store_commit_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_rb        (st_rb),
    .st_ready     (st_ready),
    .commit_valid (commit_valid),
    .commit_rb    (commit_rb),
    .flush        (flush),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ack      (mem_ack),
    .commit_err   (commit_err),
`ifdef STORE_FWD_EN
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_hit       (ld_hit),
    .ld_data      (ld_data),
`endif
    .empty        (empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: slot table plus a queue of committed slot numbers in commit order
  bit          m_busy [D];
  bit          m_comm [D];
  logic [31:0] m_addr [D];
  logic [31:0] m_data [D];
  logic [2:0]  m_rb   [D];
  int          m_q[$];
  bit          m_err;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_busy[i] = 1'b0;
      m_comm[i] = 1'b0;
    end
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                            input logic [2:0] srb, input bit cv, input logic [2:0] crb,
                            input bit fl, input bit ack);
    int cap = -1;
    int hit = -1;
    int ps;
    if (sv && !fl)
      for (int i = D - 1; i >= 0; i--) if (!m_busy[i]) cap = i;
    if (cv) begin
      for (int i = D - 1; i >= 0; i--)
        if (m_busy[i] && !m_comm[i] && m_rb[i] == crb) hit = i;
      if (hit < 0 && cap >= 0 && srb == crb) hit = cap;
    end
    m_err = cv && (hit < 0);
    if (ack && m_q.size() > 0) begin
      ps = m_q.pop_front();
      m_busy[ps] = 1'b0;
      m_comm[ps] = 1'b0;
    end
    if (cap >= 0) begin
      m_busy[cap] = 1'b1;
      m_comm[cap] = 1'b0;
      m_addr[cap] = sa;
      m_data[cap] = sd;
      m_rb[cap]   = srb;
    end
    if (hit >= 0) begin
      m_comm[hit] = 1'b1;
      m_q.push_back(hit);
    end
    if (fl)
      for (int i = 0; i < D; i++) if (m_busy[i] && !m_comm[i]) m_busy[i] = 1'b0;
  endtask

  function automatic bit tag_pending(input logic [2:0] t);
    for (int i = 0; i < D; i++) if (m_busy[i] && !m_comm[i] && m_rb[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_model();
    int nb = 0;
    logic [31:0] ea, ed;
    for (int i = 0; i < D; i++) nb += int'(m_busy[i]);
    ea = (m_q.size() > 0) ? m_addr[m_q[0]] : 32'h0;
    ed = (m_q.size() > 0) ? m_data[m_q[0]] : 32'h0;
    check_eq("model.st_ready",   32'(st_ready),   32'(nb < D));
    check_eq("model.empty",      32'(empty),      32'(nb == 0));
    check_eq("model.mem_req",    32'(mem_req),    32'(m_q.size() > 0));
    check_eq("model.mem_addr",   mem_addr,        ea);
    check_eq("model.mem_data",   mem_data,        ed);
    check_eq("model.commit_err", 32'(commit_err), 32'(m_err));
  endtask

  // One clock: drive, compare on the falling edge, advance the model on the rising edge
  task automatic cycle(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [2:0] srb, input bit cv, input logic [2:0] crb,
                       input bit fl, input bit ack);
    st_valid = sv; st_addr = sa; st_data = sd; st_rb = srb;
    commit_valid = cv; commit_rb = crb; flush = fl; mem_ack = ack;
    @(negedge clk);
    compare_model();
    @(posedge clk);
    model_step(sv, sa, sd, srb, cv, crb, fl, ack);
    #1;
  endtask

  task automatic idle(input bit ack);
    cycle(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 3'd0, 1'b0, ack);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] rb);
    cycle(1'b1, a, d, rb, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic commit(input logic [2:0] rb);
    cycle(1'b0, 32'h0, 32'h0, 3'd0, 1'b1, rb, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    st_valid = 0; st_addr = 0; st_data = 0; st_rb = 0;
    commit_valid = 0; commit_rb = 0; flush = 0; mem_ack = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0]  r_tag;
    logic [2:0]  c_tag;
    bit          r_sv;
    int          pend[$];

    do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst.st_ready",   32'(st_ready),   32'd1);
    check_eq("rst.empty",      32'(empty),      32'd1);
    check_eq("rst.mem_req",    32'(mem_req),    32'd0);
    check_eq("rst.commit_err", 32'(commit_err), 32'd0);
    check_eq("rst.mem_addr",   mem_addr,        32'h0);
    reset = 1'b0;

    // Basic store, commit, drain
    do_reset();
    store(32'h10, 32'hAA, 3'd2);
    check_eq("basic.no_req_before_commit", 32'(mem_req), 32'd0);
    commit(3'd2);
    check_eq("basic.mem_req",  32'(mem_req), 32'd1);
    check_eq("basic.mem_addr", mem_addr,     32'h10);
    check_eq("basic.mem_data", mem_data,     32'hAA);
    idle(1'b1);
    check_eq("basic.empty",    32'(empty),   32'd1);

    // Fill all slots, overflow attempt, free one
    do_reset();
    for (int t = 0; t < 4; t++) store(32'h40 + 32'(4 * t), 32'(t), 3'(t));
    check_eq("full.st_ready", 32'(st_ready), 32'd0);
    store(32'h50, 32'h55, 3'd4);
    check_eq("full.st_ready_5th", 32'(st_ready), 32'd0);
    commit(3'd0);
    idle(1'b1);
    check_eq("full.st_ready_after_ack", 32'(st_ready), 32'd1);
    commit(3'd4);
    check_eq("full.5th_dropped_err", 32'(commit_err), 32'd1);

    // Capture-commit bypass drains after the earlier commit
    do_reset();
    store(32'h30, 32'h3, 3'd1);
    commit(3'd1);
    cycle(1'b1, 32'h34, 32'h4, 3'd3, 1'b1, 3'd3, 1'b0, 1'b0);
    check_eq("bypass.err",       32'(commit_err), 32'd0);
    check_eq("bypass.head_addr", mem_addr,        32'h30);
    idle(1'b1);
    check_eq("bypass.second_req",  32'(mem_req), 32'd1);
    check_eq("bypass.second_addr", mem_addr,     32'h34);
    idle(1'b1);
    check_eq("bypass.empty", 32'(empty), 32'd1);

    // Flush keeps only the committed store
    do_reset();
    store(32'h100, 32'h11, 3'd1);
    commit(3'd1);
    store(32'h104, 32'h44, 3'd4);
    store(32'h108, 32'h55, 3'd5);
    cycle(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    check_eq("flush.mem_addr", mem_addr, 32'h100);
    idle(1'b1);
    check_eq("flush.no_more_req", 32'(mem_req), 32'd0);
    check_eq("flush.empty",       32'(empty),   32'd1);
    commit(3'd4);
    check_eq("flush.commit_err", 32'(commit_err), 32'd1);
    idle(1'b0);
    check_eq("flush.err_one_cycle", 32'(commit_err), 32'd0);

    // Reset in the middle of an unacknowledged write
    do_reset();
    store(32'h200, 32'h22, 3'd6);
    commit(3'd6);
    check_eq("midrst.req_before", 32'(mem_req), 32'd1);
    commit_valid = 1'b0; mem_ack = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("midrst.req_now",  32'(mem_req),  32'd0);
    check_eq("midrst.addr_now", mem_addr,      32'h0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    idle(1'b1);
    check_eq("midrst.late_ack_req",   32'(mem_req),  32'd0);
    check_eq("midrst.late_ack_empty", 32'(empty),    32'd1);
    check_eq("midrst.late_ack_ready", 32'(st_ready), 32'd1);

`ifdef STORE_FWD_EN
    do_reset();
    store(32'h20, 32'h1, 3'd1);
    store(32'h20, 32'h2, 3'd2);
    commit(3'd1);
    commit(3'd2);
    ld_valid = 1'b1; ld_addr = 32'h20;
    #1;
    check_eq("fwd.hit",  32'(ld_hit), 32'd1);
    check_eq("fwd.data", ld_data,     32'h2);
    ld_valid = 1'b0;
    #1;
    check_eq("fwd.no_valid", 32'(ld_hit), 32'd0);
`endif

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r_tag = 3'($urandom_range(0, 7));
      r_sv  = ($urandom_range(0, 1) == 1) && !tag_pending(r_tag);
      pend.delete();
      for (int i = 0; i < D; i++) if (m_busy[i] && !m_comm[i]) pend.push_back(int'(m_rb[i]));
      case ($urandom_range(0, 3))
        0:       c_tag = r_tag;
        1:       c_tag = 3'($urandom_range(0, 7));
        default: c_tag = (pend.size() > 0) ? 3'(pend[$urandom_range(0, pend.size() - 1)])
                                           : 3'($urandom_range(0, 7));
      endcase
      cycle(r_sv, {26'($urandom_range(0, 15)), 6'h0}, $urandom, r_tag,
            ($urandom_range(0, 2) != 0), c_tag, ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 1) == 1));
    end
    for (int n = 0; n < 8; n++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
